// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port VRAM between a display
// reader and a CPU. CPU writes are posted into a one-entry write buffer and
// acknowledged straight away. CPU reads that hit the buffer are answered from
// it. Everything else competes for the VRAM under a one-bit round robin
// pointer.
module vram_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_valid,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_din,
    output logic          vram_we,
    input  logic [DW-1:0] vram_dout,
    output logic          err,
    output logic [15:0]   conf_cnt
);

    // Per-side access progress. ISSUED is the cycle the VRAM sees the
    // address. RETURN is the cycle the RAM data and the ack are presented.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_RETURN = 2'd2
    } side_state_t;

    localparam logic PTR_VGA = 1'b0;

    side_state_t   vga_state;
    side_state_t   cpu_state;
    logic          vga_hold;
    logic          cpu_hold;
    logic          cpu_drain_q;
    logic          cpu_from_vram;
    logic          ptr;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic [DW-1:0] cpu_rdata_q;

    logic vga_elig;
    logic cpu_new;
    logic cpu_is_wr;
    logic cpu_is_rd;
    logic buf_hit;
    logic cpu_miss;
    logic cpu_drain;
    logic cpu_elig;
    logic contend;
    logic grant_vga;
    logic grant_cpu;

    // Eligibility and the round robin decision for this edge. A side is
    // masked while it has an access in flight, during its ack cycle, and for
    // one cycle after the ack. This stops a request level that is still held
    // high from being taken as a second request.
    always_comb begin
        vga_elig  = vga_req && (vga_state == S_IDLE) && !vga_hold;
        cpu_new   = (cpu_state == S_IDLE) && !cpu_ready && !cpu_hold;
        cpu_is_wr = cpu_new && cpu_wr;
        cpu_is_rd = cpu_new && cpu_rd && !cpu_wr;
        buf_hit   = buf_valid && (buf_addr == cpu_addr);
        cpu_miss  = cpu_is_rd && !buf_hit;
        cpu_drain = cpu_is_wr && buf_valid;
        cpu_elig  = cpu_miss || cpu_drain;
        contend   = vga_elig && cpu_elig;
        grant_vga = vga_elig && (!cpu_elig || (ptr == PTR_VGA));
        grant_cpu = cpu_elig && !grant_vga;
    end

    // The RAM data is only valid in the return cycle, so it passes straight
    // through to whichever side is being acknowledged.
    always_comb begin
        vga_rdata = vga_valid ? vram_dout : '0;
        cpu_rdata = cpu_from_vram ? vram_dout : cpu_rdata_q;
    end

    // Arbiter state, per-side FSMs, write buffer and registered VRAM port.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vga_state     <= S_IDLE;
            cpu_state     <= S_IDLE;
            vga_hold      <= 1'b0;
            cpu_hold      <= 1'b0;
            cpu_drain_q   <= 1'b0;
            cpu_from_vram <= 1'b0;
            ptr           <= PTR_VGA;
            buf_valid     <= 1'b0;
            buf_addr      <= '0;
            buf_data      <= '0;
            cpu_rdata_q   <= '0;
            cpu_ready     <= 1'b0;
            vga_valid     <= 1'b0;
            vram_addr     <= '0;
            vram_din      <= '0;
            vram_we       <= 1'b0;
            err           <= 1'b0;
            conf_cnt      <= '0;
        end else begin
            vram_we       <= 1'b0;
            cpu_ready     <= 1'b0;
            vga_valid     <= 1'b0;
            cpu_from_vram <= 1'b0;
            vga_hold      <= (vga_state == S_RETURN);
            cpu_hold      <= cpu_ready;

            if (cpu_rd && cpu_wr) begin
                err <= 1'b1;
            end

            if (contend) begin
                ptr <= ~ptr;
                if (conf_cnt != 16'hFFFF) begin
                    conf_cnt <= conf_cnt + 16'd1;
                end
            end

            case (vga_state)
                S_IDLE: begin
                    if (grant_vga) begin
                        vga_state <= S_ISSUED;
                        vram_addr <= vga_addr;
                    end
                end
                S_ISSUED: begin
                    vga_state <= S_RETURN;
                    vga_valid <= 1'b1;
                end
                default: begin
                    vga_state <= S_IDLE;
                end
            endcase

            case (cpu_state)
                S_IDLE: begin
                    if (grant_cpu) begin
                        cpu_state   <= S_ISSUED;
                        cpu_drain_q <= cpu_drain;
                        if (cpu_drain) begin
                            vram_addr <= buf_addr;
                            vram_din  <= buf_data;
                            vram_we   <= 1'b1;
                            buf_valid <= 1'b0;
                        end else begin
                            vram_addr <= cpu_addr;
                        end
                    end else if (cpu_is_wr && !buf_valid) begin
                        buf_valid <= 1'b1;
                        buf_addr  <= cpu_addr;
                        buf_data  <= cpu_wdata;
                        cpu_ready <= 1'b1;
                    end else if (cpu_is_rd && buf_hit) begin
                        cpu_rdata_q <= buf_data;
                        cpu_ready   <= 1'b1;
                    end
                end
                S_ISSUED: begin
                    if (cpu_drain_q) begin
                        cpu_state <= S_IDLE;
                    end else begin
                        cpu_state     <= S_RETURN;
                        cpu_ready     <= 1'b1;
                        cpu_from_vram <= 1'b1;
                    end
                end
                default: begin
                    cpu_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized CPU/display traffic.
// Expected responses are queued when requests are issued, and a monitor
// compares them against the acks. The CPU view of memory is modelled as
// "the latest value written to an address". The display only reads a region
// the CPU never writes, so its expected data is the RAM's initial contents.
module tb_vram_arbiter;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        clrn;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic [15:0] vga_rdata;
    logic        vga_valid;
    logic [11:0] vram_addr;
    logic [15:0] vram_din;
    logic        vram_we;
    logic [15:0] vram_dout;
    logic        err;
    logic [15:0] conf_cnt;

    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } cpu_exp_t;

    cpu_exp_t    cpu_q[$];
    logic [15:0] vga_q[$];

    logic [15:0] ram_data    [0:4095];
    bit          ram_written [0:4095];
    logic [15:0] ref_data    [0:4095];
    bit          ref_written [0:4095];

    vram_arbiter #(.AW(12), .DW(16)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_rdata (vga_rdata),
        .vga_valid (vga_valid),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .vram_we   (vram_we),
        .vram_dout (vram_dout),
        .err       (err),
        .conf_cnt  (conf_cnt)
    );

    always #5 clk = ~clk;

    // Power-on contents of the VRAM.
    function automatic logic [15:0] init_val(input logic [11:0] a);
        if (a == 12'h010) return 16'hA5A5;
        return {a, 4'h0} ^ 16'h5A3C;
    endfunction

    // What a CPU read of address a should return.
    function automatic logic [15:0] model_read(input logic [11:0] a);
        return ref_written[a] ? ref_data[a] : init_val(a);
    endfunction

    // Synchronous single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (vram_we === 1'b1) begin
            ram_data[vram_addr]    <= vram_din;
            ram_written[vram_addr] <= 1'b1;
        end
        vram_dout <= ram_written[vram_addr] ? ram_data[vram_addr] : init_val(vram_addr);
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    cpu_exp_t    mon_cpu;
    logic [15:0] mon_vga;

    // Scoreboard monitor: every ack consumes the oldest expected response.
    always @(negedge clk) begin
        if (clrn === 1'b1) begin
            if (vga_valid === 1'b1) begin
                if (vga_q.size() == 0) begin
                    check_output("unexpected_vga_valid", 32'd1, 32'd0);
                end else begin
                    mon_vga = vga_q.pop_front();
                    check_output("sb_vga_rdata", {16'h0, vga_rdata}, {16'h0, mon_vga});
                end
            end
            if (cpu_ready === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    check_output("unexpected_cpu_ready", 32'd1, 32'd0);
                end else begin
                    mon_cpu = cpu_q.pop_front();
                    if (mon_cpu.is_read) begin
                        check_output("sb_cpu_rdata", {16'h0, cpu_rdata}, {16'h0, mon_cpu.data});
                    end
                end
            end
        end
    end

    // One CPU transaction: hold the request until ready, then drop it and
    // stay quiet for one cycle.
    task automatic apply_cpu_stimulus(input bit rd, input bit wr, input logic [11:0] addr,
                                      input logic [15:0] data, output int lat,
                                      output bit we_seen);
        cpu_exp_t e;
        @(negedge clk);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = data;
        e.is_read = rd && !wr;
        e.data    = e.is_read ? model_read(addr) : 16'h0;
        cpu_q.push_back(e);
        if (wr) begin
            ref_data[addr]    = data;
            ref_written[addr] = 1'b1;
        end
        lat     = 0;
        we_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (vram_we === 1'b1) we_seen = 1'b1;
        end while (cpu_ready !== 1'b1 && lat < TO);
        if (cpu_ready !== 1'b1) begin
            check_output("cpu_ack_timeout", 32'd0, 32'd1);
            void'(cpu_q.pop_back());
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
    endtask

    // One display read, same handshake as the CPU side.
    task automatic apply_vga_stimulus(input logic [11:0] addr, output int lat);
        @(negedge clk);
        vga_req  = 1'b1;
        vga_addr = addr;
        vga_q.push_back(init_val(addr));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (vga_valid !== 1'b1 && lat < TO);
        if (vga_valid !== 1'b1) begin
            check_output("vga_ack_timeout", 32'd0, 32'd1);
            void'(vga_q.pop_back());
        end
        vga_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cpu_ready"}, {31'h0, cpu_ready}, 32'd0);
        check_output({tag, "_vga_valid"}, {31'h0, vga_valid}, 32'd0);
        check_output({tag, "_vram_we"},   {31'h0, vram_we},   32'd0);
        check_output({tag, "_err"},       {31'h0, err},       32'd0);
        check_output({tag, "_vram_addr"}, {20'h0, vram_addr}, 32'd0);
        check_output({tag, "_vram_din"},  {16'h0, vram_din},  32'd0);
        check_output({tag, "_cpu_rdata"}, {16'h0, cpu_rdata}, 32'd0);
        check_output({tag, "_vga_rdata"}, {16'h0, vga_rdata}, 32'd0);
        check_output({tag, "_conf_cnt"},  {16'h0, conf_cnt},  32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // Hard stop in case a wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int lat_d;
    bit we_d;
    int seen;
    int seq[$];

    initial begin
        clrn      = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;
        #1;
        clrn = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        // Lone display read with exact timing.
        @(negedge clk);
        vga_addr = 12'h010;
        vga_req  = 1'b1;
        vga_q.push_back(16'hA5A5);
        @(negedge clk);
        check_output("vga_issue_addr", {20'h0, vram_addr}, 32'h010);
        check_output("vga_issue_we", {31'h0, vram_we}, 32'd0);
        check_output("vga_early_valid", {31'h0, vga_valid}, 32'd0);
        @(negedge clk);
        check_output("vga_valid_on_time", {31'h0, vga_valid}, 32'd1);
        check_output("vga_rdata_a5a5", {16'h0, vga_rdata}, 32'hA5A5);
        check_output("vga_lone_conf_cnt", {16'h0, conf_cnt}, 32'd0);
        vga_req = 1'b0;
        @(negedge clk);
        check_output("vga_valid_one_cycle", {31'h0, vga_valid}, 32'd0);
        @(negedge clk);

        // Posted write then a read forwarded from the buffer.
        apply_cpu_stimulus(1'b0, 1'b1, 12'h020, 16'h1234, lat_d, we_d);
        check_output("post_wr_latency", lat_d, 32'd1);
        check_output("post_wr_no_vram", {31'h0, we_d}, 32'd0);
        apply_cpu_stimulus(1'b1, 1'b0, 12'h020, 16'h0, lat_d, we_d);
        check_output("fwd_rd_latency", lat_d, 32'd1);
        check_output("fwd_rd_no_vram", {31'h0, we_d}, 32'd0);

        // A buffered write that never drained is lost across reset.
        pulse_reset("rst_a");
        ref_written[12'h020] = 1'b0;

        // Full buffer: second write waits for the drain of the first.
        apply_cpu_stimulus(1'b0, 1'b1, 12'h030, 16'hBEEF, lat_d, we_d);
        check_output("first_wr_latency", lat_d, 32'd1);
        apply_cpu_stimulus(1'b0, 1'b1, 12'h031, 16'hCAFE, lat_d, we_d);
        check_output("full_wr_latency", lat_d, 32'd3);
        check_output("full_wr_drained", {31'h0, we_d}, 32'd1);
        check_output("drain_ram_030", ram_written[12'h030] ? {16'h0, ram_data[12'h030]} : 32'h0,
                     32'hBEEF);
        apply_cpu_stimulus(1'b1, 1'b0, 12'h030, 16'h0, lat_d, we_d);
        check_output("miss_rd_latency", lat_d, 32'd2);
        apply_cpu_stimulus(1'b1, 1'b0, 12'h031, 16'h0, lat_d, we_d);
        check_output("hit_rd_latency", lat_d, 32'd1);

        // Contention: both sides held, acks must alternate VGA, CPU, VGA, CPU.
        @(negedge clk);
        vga_addr = 12'h040;
        cpu_addr = 12'h050;
        vga_req  = 1'b1;
        cpu_rd   = 1'b1;
        vga_q.push_back(init_val(12'h040));
        vga_q.push_back(init_val(12'h040));
        cpu_q.push_back('{is_read: 1'b1, data: model_read(12'h050)});
        cpu_q.push_back('{is_read: 1'b1, data: model_read(12'h050)});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (vga_valid === 1'b1) seq.push_back(0);
            if (cpu_ready === 1'b1) seq.push_back(1);
        end
        vga_req = 1'b0;
        cpu_rd  = 1'b0;
        check_output("contend_ack_count", seq.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("contend_order_%0d", i),
                         (i < seq.size()) ? seq[i] : 32'hFF, i % 2);
        end
        check_output("contend_conf_cnt", {16'h0, conf_cnt}, 32'd1);
        @(negedge clk);
        @(negedge clk);

        // Protocol error: both strobes act as a write and set a sticky err.
        apply_cpu_stimulus(1'b1, 1'b1, 12'h060, 16'h7777, lat_d, we_d);
        check_output("both_as_write_latency", lat_d, 32'd3);
        check_output("err_set", {31'h0, err}, 32'd1);
        apply_cpu_stimulus(1'b1, 1'b0, 12'h060, 16'h0, lat_d, we_d);
        check_output("both_then_hit_latency", lat_d, 32'd1);
        check_output("err_sticky", {31'h0, err}, 32'd1);
        pulse_reset("rst_err");
        ref_written[12'h060] = 1'b0;
        @(negedge clk);

        // Reset in the grant cycle discards the display read.
        @(negedge clk);
        vga_addr = 12'h210;
        vga_req  = 1'b1;
        @(negedge clk);
        check_output("midrd_granted", {20'h0, vram_addr}, 32'h210);
        clrn    = 1'b0;
        vga_req = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vga_valid === 1'b1) seen++;
        end
        check_output("midrd_no_ack", seen, 32'd0);

        // First grant at the first edge after reset release.
        @(negedge clk);
        clrn     = 1'b0;
        vga_addr = 12'h211;
        vga_req  = 1'b1;
        vga_q.push_back(init_val(12'h211));
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check_output("first_grant_addr", {20'h0, vram_addr}, 32'h211);
        @(negedge clk);
        check_output("first_grant_valid", {31'h0, vga_valid}, 32'd1);
        vga_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Randomized concurrent traffic.
        fork
            begin
                int lat_c;
                bit we_c;
                for (int i = 0; i < 60; i++) begin
                    logic [11:0] a;
                    a = 12'h100 + 12'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1)
                        apply_cpu_stimulus(1'b0, 1'b1, a, 16'($urandom), lat_c, we_c);
                    else
                        apply_cpu_stimulus(1'b1, 1'b0, a, 16'h0, lat_c, we_c);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                int lat_v;
                for (int i = 0; i < 60; i++) begin
                    apply_vga_stimulus(12'h200 | 12'($urandom_range(0, 255)), lat_v);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);

        check_output("cpu_q_empty", cpu_q.size(), 32'd0);
        check_output("vga_q_empty", vga_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
